urv_dm_wb_bridge: RTL and testbench

Data-memory bus bridge directly downstream of the uRV core's data-memory port. It accepts one load or store from the core at a time and runs it as a single pipelined Wishbone B4 master cycle. It then returns load data, a load-done or store-done pulse, and a bus-error pulse on ERR or timeout.

---
 rtl/urv_dm_wb_bridge_pkg.sv | 22 ++
 rtl/urv_bus_timeout.sv | 39 +++
 rtl/urv_dm_wb_bridge.sv | 155 +++++++++++++++
 tb/tb_urv_dm_wb_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/urv_dm_wb_bridge_pkg.sv
// rtl/urv_dm_wb_bridge_pkg.sv - shared definitions for the uRV data-memory Wishbone bridge
//
// Purpose: FSM state encoding, default error word and the timeout counter
// width helper used by urv_dm_wb_bridge and urv_bus_timeout.
// Ports: none (package).
package urv_dm_wb_bridge_pkg;

  // IDLE: ready for a request; REQ: STB asserted; WAIT: STB accepted, awaiting ACK/ERR.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_t;

  localparam logic [31:0] URV_DEFAULT_ERR_DATA = 32'h0000_0000;

  // At least 8 bits, wider only when the timeout value needs it.
  function automatic int timeout_width(input int timeout);
    return (timeout > 255) ? $clog2(timeout + 1) : 8;
  endfunction

endpackage

// File: rtl/urv_bus_timeout.sv
// rtl/urv_bus_timeout.sv - bus access watchdog counter
//
// Purpose: counts cycles while a Wishbone cycle is open and flags the last
// allowed cycle. g_timeout == 0 disables the watchdog.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clear          : restart the count (new access accepted)
//   enable         : count this cycle (CYC high)
//   expired        : this is cycle g_timeout of the access with no response yet
module urv_bus_timeout
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int g_timeout = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = timeout_width(g_timeout);
  localparam logic [TW-1:0] LAST = TW'(g_timeout - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (g_timeout != 0) && enable && (count == LAST);

endmodule

// File: rtl/urv_dm_wb_bridge.sv
// rtl/urv_dm_wb_bridge.sv - uRV data-memory port to pipelined Wishbone B4 master bridge
//
// Purpose: runs one core load/store at a time as a single pipelined Wishbone
// cycle and returns load data plus registered done / bus-error pulses.
// Ports:
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   dm_addr_i/dm_data_s_i     : core byte address and store data
//   dm_data_select_i          : core byte enables
//   dm_load_i/dm_store_i      : requests, taken when dm_ready_o is high
//   dm_ready_o                : bridge idle
//   dm_data_l_o               : load data, held until the next load completes
//   dm_load_done_o/dm_store_done_o/bus_err_o : one-cycle completion pulses
//   wb_*                      : Wishbone B4 pipelined master
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int          g_timeout  = 255,
  parameter logic [31:0] g_err_data = URV_DEFAULT_ERR_DATA
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  bus_state_t  state_q, state_d;
  logic [29:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] data_l_q;
  logic        load_done_q, store_done_q, err_q;

  logic accept, complete, complete_err, expired;

  // Bus is word addressed; the byte offset is carried by SEL.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dm_addr_i[1:0];

  urv_bus_timeout #(
    .g_timeout(g_timeout)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clear  (accept),
    .enable (wb_cyc_o),
    .expired(expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    complete     = 1'b0;
    complete_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_load_i || dm_store_i) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A response is only meaningful once the STB has been taken.
        if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
          complete     = 1'b1;
          complete_err = wb_err_i;
        end else if (expired) begin
          complete     = 1'b1;
          complete_err = 1'b1;
        end else if (!wb_stall_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wb_ack_i || wb_err_i) begin
          complete     = 1'b1;
          complete_err = wb_err_i;
        end else if (expired) begin
          complete     = 1'b1;
          complete_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      data_l_q     <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        adr_q <= dm_addr_i[31:2];
        dat_q <= dm_data_s_i;
        sel_q <= dm_data_select_i;
        // A simultaneous load+store request runs as the store.
        we_q  <= dm_store_i;
      end
      if (complete && !we_q) begin
        data_l_q <= complete_err ? g_err_data : wb_dat_i;
      end
      load_done_q  <= complete && !we_q;
      store_done_q <= complete && we_q;
      err_q        <= complete && complete_err;
    end
  end

  assign dm_ready_o      = (state_q == ST_IDLE);
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign bus_err_o       = err_q;
  assign wb_cyc_o        = (state_q != ST_IDLE);
  assign wb_stb_o        = (state_q == ST_REQ);
  assign wb_we_o         = we_q;
  assign wb_adr_o        = {adr_q, 2'b00};
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = dat_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// tb/tb_urv_dm_wb_bridge.sv - self-checking bench for urv_dm_wb_bridge
module tb_urv_dm_wb_bridge;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam logic [1:0] R_ACK = 2'd0, R_ERR = 2'd1, R_BOTH = 2'd2, R_NONE = 2'd3;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [7:0]  stall;
    logic [7:0]  waitc;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        exp_ld;
    logic        exp_st;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] exp_adr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dm_addr = '0, dm_data_s = '0, wb_dat_i = '0;
  logic [3:0]  dm_sel = '0;
  logic dm_load = 1'b0, dm_store = 1'b0, wb_ack = 1'b0, wb_err = 1'b0, wb_stall = 1'b0;
  logic dm_ready, ld_done, st_done, bus_err, wb_cyc, wb_stb, wb_we;
  logic [31:0] dm_data_l, wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;

  urv_dm_wb_bridge #(.g_timeout(16), .g_err_data(ERR_WORD)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_ready_o(dm_ready),
    .dm_data_l_o(dm_data_l), .dm_load_done_o(ld_done), .dm_store_done_o(st_done),
    .bus_err_o(bus_err), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall)
  );

  // Second instance with the watchdog disabled.
  logic [31:0] z_addr = '0, z_dat_i = '0;
  logic z_load = 1'b0, z_ack = 1'b0;
  logic z_ready, z_ld_done, z_st_done, z_err, z_cyc, z_stb, z_we;
  logic [31:0] z_data_l, z_adr, z_dat_o;
  logic [3:0]  z_sel;

  urv_dm_wb_bridge #(.g_timeout(0), .g_err_data(ERR_WORD)) u_dut_nto (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(z_addr), .dm_data_s_i(32'h0), .dm_data_select_i(4'hF),
    .dm_load_i(z_load), .dm_store_i(1'b0), .dm_ready_o(z_ready),
    .dm_data_l_o(z_data_l), .dm_load_done_o(z_ld_done), .dm_store_done_o(z_st_done),
    .bus_err_o(z_err), .wb_cyc_o(z_cyc), .wb_stb_o(z_stb), .wb_we_o(z_we),
    .wb_adr_o(z_adr), .wb_sel_o(z_sel), .wb_dat_o(z_dat_o), .wb_dat_i(z_dat_i),
    .wb_ack_i(z_ack), .wb_err_i(1'b0), .wb_stall_i(1'b0)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] sel,
                              input int stall, input int waitc, input logic [1:0] resp,
                              input logic [31:0] rdata, input logic eld, input logic est,
                              input logic eerr, input logic [31:0] edata,
                              input logic [31:0] eadr);
    vec_t v;
    v.is_load = ld;  v.is_store = st;  v.addr = addr;  v.wdata = wdata;  v.sel = sel;
    v.stall = 8'(stall);  v.waitc = 8'(waitc);  v.resp = resp;  v.rdata = rdata;
    v.exp_ld = eld;  v.exp_st = est;  v.exp_err = eerr;  v.exp_data = edata;  v.exp_adr = eadr;
    return v;
  endfunction

  // One access: request, slave stalls for v.stall cycles, then answers v.waitc
  // cycles after the STB is taken (or never, for R_NONE -> watchdog at cycle 15).
  task automatic run_vec(input vec_t v, input int idx);
    int e;
    string tag;
    tag = $sformatf("v%0d", idx);
    e = (v.resp == R_NONE) ? 15 : int'(v.stall) + int'(v.waitc);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(dm_ready), 32'd1);
    dm_load = v.is_load;  dm_store = v.is_store;
    dm_addr = v.addr;  dm_data_s = v.wdata;  dm_sel = v.sel;
    for (int c = 0; c <= e; c++) begin
      @(negedge clk);
      dm_load = 1'b0;  dm_store = 1'b0;
      dm_addr = 32'hFFFF_FFFF;  dm_data_s = 32'h0;  dm_sel = 4'h0;
      chk({tag, "_cyc_stb"}, 32'({wb_cyc, wb_stb, ld_done, st_done, bus_err}),
          32'({1'b1, 1'(c <= int'(v.stall)), 3'b000}));
      chk({tag, "_adr"}, wb_adr, v.exp_adr);
      chk({tag, "_we_sel"}, 32'({wb_we, wb_sel}), 32'({v.is_store, v.sel}));
      chk({tag, "_dat"}, wb_dat_o, v.wdata);
      wb_stall = (c < int'(v.stall));
      wb_ack   = (c == e) && (v.resp == R_ACK || v.resp == R_BOTH);
      wb_err   = (c == e) && (v.resp == R_ERR || v.resp == R_BOTH);
      wb_dat_i = (c == e) ? v.rdata : 32'h5555_5555;
    end
    @(negedge clk);
    wb_stall = 1'b0;  wb_ack = 1'b0;  wb_err = 1'b0;  wb_dat_i = 32'h0;
    chk({tag, "_done"}, 32'({ld_done, st_done, bus_err}), 32'({v.exp_ld, v.exp_st, v.exp_err}));
    chk({tag, "_data"}, dm_data_l, v.exp_data);
    chk({tag, "_idle"}, 32'({wb_cyc, wb_stb, dm_ready}), 32'b001);
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'({ld_done, st_done, bus_err}), 32'b000);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(1, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, R_ACK, 32'hCAFE_F00D,
                 1, 0, 0, 32'hCAFE_F00D, 32'h0000_0100);
    vecs[1] = mk(0, 1, 32'h0000_0203, 32'h1234_5678, 4'b0011, 3, 2, R_ACK, 32'h0,
                 0, 1, 0, 32'hCAFE_F00D, 32'h0000_0200);
    vecs[2] = mk(1, 0, 32'h0000_0040, 32'h0, 4'hF, 0, 1, R_ERR, 32'h7777_7777,
                 1, 0, 1, ERR_WORD, 32'h0000_0040);
    vecs[3] = mk(1, 0, 32'h0000_0044, 32'h0, 4'hF, 1, 0, R_BOTH, 32'h1111_1111,
                 1, 0, 1, ERR_WORD, 32'h0000_0044);
    vecs[4] = mk(1, 0, 32'hFFFF_FFFE, 32'h0, 4'b1100, 0, 0, R_ACK, 32'h0BAD_F00D,
                 1, 0, 0, 32'h0BAD_F00D, 32'hFFFF_FFFC);
    vecs[5] = mk(1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 0, R_NONE, 32'h0,
                 1, 0, 1, ERR_WORD, 32'h0000_0300);
    vecs[6] = mk(1, 1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 0, R_ACK, 32'h2222_2222,
                 0, 1, 0, ERR_WORD, 32'h0000_0010);
    vecs[7] = mk(0, 1, 32'h0000_0020, 32'h0F0F_0F0F, 4'b0001, 20, 0, R_NONE, 32'h0,
                 0, 1, 1, ERR_WORD, 32'h0000_0020);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({dm_ready, ld_done, st_done, bus_err, wb_cyc, wb_stb, wb_we}), 32'b1000000);
    chk("rst_bus", wb_adr | wb_dat_o | 32'(wb_sel), 32'h0);
    chk("rst_data", dm_data_l, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Stray ACK/ERR while idle
    @(negedge clk);
    wb_ack = 1'b1;  wb_err = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack", 32'({ld_done, st_done, bus_err, wb_cyc}), 32'b0000);
    end
    wb_ack = 1'b0;  wb_err = 1'b0;

    // Back-to-back: load issued in the store-done cycle
    @(negedge clk);
    dm_store = 1'b1;  dm_addr = 32'h0000_0500;  dm_data_s = 32'h0BEE_F00D;  dm_sel = 4'hF;
    @(negedge clk);
    dm_store = 1'b0;  wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("b2b_store_done", 32'({st_done, dm_ready}), 32'b11);
    dm_load = 1'b1;  dm_addr = 32'h0000_0504;
    @(negedge clk);
    dm_load = 1'b0;
    chk("b2b_load_req", 32'({wb_cyc, wb_stb, wb_we, st_done}), 32'b1100);
    chk("b2b_adr", wb_adr, 32'h0000_0504);
    wb_ack = 1'b1;  wb_dat_i = 32'h1357_9BDF;
    @(negedge clk);
    wb_ack = 1'b0;  wb_dat_i = 32'h0;
    chk("b2b_load_done", 32'({ld_done, bus_err}), 32'b10);
    chk("b2b_data", dm_data_l, 32'h1357_9BDF);

    // Asynchronous reset while in WAIT
    @(negedge clk);
    dm_load = 1'b1;  dm_addr = 32'h0000_0700;
    @(negedge clk);
    dm_load = 1'b0;
    @(negedge clk);
    chk("ar_wait", 32'({wb_cyc, wb_stb}), 32'b10);
    #2 rst_n = 1'b0;
    #1 chk("ar_async", 32'({wb_cyc, wb_stb, dm_ready}), 32'b001);
    wb_ack = 1'b1;  wb_dat_i = 32'hFEED_FACE;
    @(negedge clk);
    chk("ar_hold", 32'({ld_done, st_done, bus_err, wb_cyc}), 32'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;  wb_dat_i = 32'h0;
    chk("ar_after", 32'({dm_ready, ld_done, st_done, bus_err, wb_cyc}), 32'b10000);
    chk("ar_data", dm_data_l, 32'h0);

    // Watchdog disabled: CYC stays up with a silent slave
    @(negedge clk);
    z_load = 1'b1;  z_addr = 32'h0000_0800;
    @(negedge clk);
    z_load = 1'b0;
    repeat (300) @(negedge clk);
    chk("nto_cyc", 32'({z_cyc, z_stb, z_ld_done, z_err, z_ready}), 32'b10000);
    z_ack = 1'b1;  z_dat_i = 32'h2468_ACE0;
    @(negedge clk);
    z_ack = 1'b0;
    chk("nto_done", 32'({z_ld_done, z_err, z_cyc}), 32'b100);
    chk("nto_data", z_data_l, 32'h2468_ACE0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
